seg_port_display: RTL and testbench



---
 rtl/seg_port_display.sv | 198 +++++++++++++++++++
 tb/tb_seg_port_display.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_port_display.sv
// seg_port_display: periodically snapshots three 32-bit output ports, converts each
// to two decimal digits with a sequential double-dabble engine and drives six
// static active-low 7-segment digits, updated atomically at the end of each pass.
module seg_port_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] out_port0,
   input  logic [31:0] out_port1,
   input  logic [31:0] out_port2,
   input  logic        refresh_now,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        busy,
   output logic        upd_done
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegDash  = 7'b0111111;

   typedef enum logic [2:0] {StIdle, StLoad, StShift, StStore, StCommit} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q;
   logic            pending_q, pending_d;
   logic [31:0]     shadow_q [3];
   logic [31:0]     shadow_d [3];
   logic [1:0]      k_q, k_d;
   logic [6:0]      shift_q, shift_d;
   logic [7:0]      bcd_q, bcd_d;
   logic [2:0]      sh_cnt_q, sh_cnt_d;
   logic            ovf_q, ovf_d;
   logic [6:0]      stage_q [6];
   logic [6:0]      stage_d [6];
   logic [6:0]      hex_q [6];
   logic [6:0]      hex_d [6];

   logic            auto_tick;
   logic            tick;
   logic [7:0]      bcd_adj;
   logic [6:0]      tens_seg;
   logic [6:0]      ones_seg;

   // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SegBlank;
      endcase
      return s;
   endfunction

   assign auto_tick = (cnt_q == CntW'(REFRESH_DIV - 1));
   assign tick      = auto_tick | refresh_now;

   assign busy     = (state_q != StIdle);
   assign upd_done = (state_q == StCommit);

   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];

   // Free-running refresh divider; keeps counting while a pass is in progress.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (auto_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // Add-3 correction of both BCD nibbles ahead of each shift.
   always_comb begin
      bcd_adj = bcd_q;
      if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
      if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
   end

   // Segment patterns for the digit pair just converted; overflow forces dashes.
   always_comb begin
      tens_seg = seg7(bcd_q[7:4]);
      ones_seg = seg7(bcd_q[3:0]);
      if (ovf_q) begin
         tens_seg = SegDash;
         ones_seg = SegDash;
      end else if (BLANK_LZ && (bcd_q[7:4] == 4'd0)) begin
         tens_seg = SegBlank;
      end
   end

   // Conversion sequencer: next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      k_d       = k_q;
      shift_d   = shift_q;
      bcd_d     = bcd_q;
      sh_cnt_d  = sh_cnt_q;
      ovf_d     = ovf_q;
      stage_d   = stage_q;
      hex_d     = hex_q;

      if (state_q != StIdle && tick) pending_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (tick || pending_q) begin
               pending_d   = 1'b0;
               shadow_d[0] = out_port0;
               shadow_d[1] = out_port1;
               shadow_d[2] = out_port2;
               k_d         = 2'd0;
               state_d     = StLoad;
            end
         end
         StLoad: begin
            ovf_d    = (shadow_q[k_q] > 32'd99);
            shift_d  = shadow_q[k_q][6:0];
            bcd_d    = 8'd0;
            sh_cnt_d = 3'd0;
            state_d  = StShift;
         end
         StShift: begin
            bcd_d    = {bcd_adj[6:0], shift_q[6]};
            shift_d  = {shift_q[5:0], 1'b0};
            sh_cnt_d = sh_cnt_q + 3'd1;
            if (sh_cnt_q == 3'd6) state_d = StStore;
         end
         StStore: begin
            stage_d[{k_q, 1'b1}] = tens_seg;
            stage_d[{k_q, 1'b0}] = ones_seg;
            if (k_q < 2'd2) begin
               k_d     = k_q + 2'd1;
               state_d = StLoad;
            end else begin
               state_d = StCommit;
            end
         end
         StCommit: begin
            hex_d   = stage_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state; reset discards any partial pass and blanks the display.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         shadow_q  <= '{default: '0};
         k_q       <= 2'd0;
         shift_q   <= 7'd0;
         bcd_q     <= 8'd0;
         sh_cnt_q  <= 3'd0;
         ovf_q     <= 1'b0;
         stage_q   <= '{default: SegBlank};
         hex_q     <= '{default: SegBlank};
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         k_q       <= k_d;
         shift_q   <= shift_d;
         bcd_q     <= bcd_d;
         sh_cnt_q  <= sh_cnt_d;
         ovf_q     <= ovf_d;
         stage_q   <= stage_d;
         hex_q     <= hex_d;
      end
   end

endmodule

// File: tb/tb_seg_port_display.sv
// Scoreboard bench for seg_port_display: expected displays are queued with their
// commit cycle when a refresh is issued and checked by a monitor on upd_done.
module tb_seg_port_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

   typedef struct {
      logic [41:0] hexes;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n, rst_ar;
   logic [31:0] p0, p1, p2;
   logic        refresh_now;
   logic [6:0]  h0, h1, h2, h3, h4, h5;
   logic        busy, upd_done;
   logic [6:0]  n0, n1, n2, n3, n4, n5;
   logic        busy_nz, done_nz;
   logic [6:0]  a0, a1, a2, a3, a4, a5;
   logic        busy_ar, done_ar;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t cur;
   logic pend = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   seg_port_display dut (
      .clock(clock), .resetn(rst_n), .out_port0(p0), .out_port1(p1), .out_port2(p2),
      .refresh_now(refresh_now), .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4),
      .hex5(h5), .busy(busy), .upd_done(upd_done)
   );

   seg_port_display #(.BLANK_LZ(1'b0)) dut_nz (
      .clock(clock), .resetn(rst_n), .out_port0(p0), .out_port1(p1), .out_port2(p2),
      .refresh_now(refresh_now), .hex0(n0), .hex1(n1), .hex2(n2), .hex3(n3), .hex4(n4),
      .hex5(n5), .busy(busy_nz), .upd_done(done_nz)
   );

   seg_port_display #(.REFRESH_DIV(40)) dut_ar (
      .clock(clock), .resetn(rst_ar), .out_port0(32'd12), .out_port1(32'd34),
      .out_port2(32'd56), .refresh_now(1'b0), .hex0(a0), .hex1(a1), .hex2(a2), .hex3(a3),
      .hex4(a4), .hex5(a5), .busy(busy_ar), .upd_done(done_ar)
   );

   function automatic logic [41:0] pk(input logic [6:0] x5, x4, x3, x2, x1, x0);
      return {x5, x4, x3, x2, x1, x0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: each commit pops one expectation, checks its cycle, then the display.
   always @(negedge clock) begin
      if (upd_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_commit", 64'(cyc), 64'hFFFF_FFFF);
         end else begin
            cur = exp_q.pop_front();
            chk("commit_cycle", 64'(cyc), 64'(cur.cyc));
            pend = 1'b1;
         end
      end else if (pend) begin
         chk("hex_after_commit", 64'(pk(h5, h4, h3, h2, h1, h0)), 64'(cur.hexes));
         pend = 1'b0;
      end
   end

   // Issue one refresh pulse, queue its expectation and let the pass finish.
   task automatic run_pass(input logic [41:0] e);
      int t;
      @(negedge clock);
      refresh_now = 1'b1;
      t = cyc;
      exp_q.push_back('{hexes: e, cyc: t + 28});
      @(negedge clock);
      refresh_now = 1'b0;
      repeat (31) @(negedge clock);
   endtask

   task automatic wait_ar_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done_ar) begin
            at = cyc;
            break;
         end
      end
      chk("ar_done_seen", 64'(at != -1), 64'd1);
   endtask

   initial begin
      int t, r, u1, u2, u3;
      rst_n = 1'b0;
      rst_ar = 1'b0;
      p0 = '0;
      p1 = '0;
      p2 = '0;
      refresh_now = 1'b0;

      // Reset
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      chk("rst_hex0", 64'(h0), 64'(SB));
      chk("rst_hex1", 64'(h1), 64'(SB));
      chk("rst_hex2", 64'(h2), 64'(SB));
      chk("rst_hex3", 64'(h3), 64'(SB));
      chk("rst_hex4", 64'(h4), 64'(SB));
      chk("rst_hex5", 64'(h5), 64'(SB));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_upd_done", 64'(upd_done), 64'd0);
      repeat (20) @(negedge clock);
      chk("no_update_before_tick", 64'(pk(h5, h4, h3, h2, h1, h0)), 64'(pk(SB, SB, SB, SB, SB, SB)));

      // Basic pass with busy/upd_done timing
      p0 = 32'd42;
      p1 = 32'd7;
      p2 = 32'd99;
      @(negedge clock);
      refresh_now = 1'b1;
      t = cyc;
      exp_q.push_back('{hexes: pk(S9, S9, SB, S7, S4, S2), cyc: t + 28});
      for (int i = 1; i <= 30; i++) begin
         @(negedge clock);
         refresh_now = 1'b0;
         chk($sformatf("busy_T+%0d", i), 64'(busy), 64'(i <= 28));
         chk($sformatf("upd_done_T+%0d", i), 64'(upd_done), 64'(i == 28));
      end

      // Clamp and zero, including the no-blanking instance
      p0 = 32'd100;
      p1 = 32'hFFFF_FFFF;
      p2 = 32'd0;
      run_pass(pk(SB, S0, SD, SD, SD, SD));
      chk("nz_hex5_zero", 64'(n5), 64'(S0));
      chk("nz_hex4_zero", 64'(n4), 64'(S0));
      chk("nz_hex1_dash", 64'(n1), 64'(SD));

      // Snapshot stability
      p0 = 32'd15;
      p1 = 32'd3;
      p2 = 32'd60;
      @(negedge clock);
      refresh_now = 1'b1;
      t = cyc;
      exp_q.push_back('{hexes: pk(S6, S0, SB, S3, S1, S5), cyc: t + 28});
      while (cyc < t + 35) begin
         @(negedge clock);
         refresh_now = 1'b0;
         if (cyc == t + 5) p0 = 32'd88;
      end
      run_pass(pk(S6, S0, SB, S3, S8, S8));

      // Pending collapse: three requests, two passes
      p0 = 32'd42;
      p1 = 32'd7;
      p2 = 32'd99;
      t = 0;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clock);
         refresh_now = (c == 0) || (c == 3) || (c == 10);
         if (c == 0) begin
            t = cyc;
            exp_q.push_back('{hexes: pk(S9, S9, SB, S7, S4, S2), cyc: t + 28});
            exp_q.push_back('{hexes: pk(S9, S9, SB, S7, S4, S2), cyc: t + 57});
         end
      end
      refresh_now = 1'b0;
      repeat (60) @(negedge clock);
      chk("pending_queue_drained", 64'(exp_q.size()), 64'd0);
      repeat (40) @(negedge clock);

      // Auto refresh and asynchronous reset mid-pass
      @(negedge clock);
      rst_ar = 1'b1;
      r = cyc;
      wait_ar_done(100, u1);
      chk("ar_first_commit", 64'(u1), 64'(r + 67));
      wait_ar_done(50, u2);
      chk("ar_period", 64'(u2 - u1), 64'd40);
      @(negedge clock);
      chk("ar_hex", 64'(pk(a5, a4, a3, a2, a1, a0)), 64'(pk(S5, S6, S3, S4, S1, S2)));
      while (cyc < u2 + 16) @(negedge clock);
      chk("ar_busy_in_shift", 64'(busy_ar), 64'd1);
      #1 rst_ar = 1'b0;
      #1;
      chk("ar_rst_hex", 64'(pk(a5, a4, a3, a2, a1, a0)), 64'(pk(SB, SB, SB, SB, SB, SB)));
      chk("ar_rst_busy", 64'(busy_ar), 64'd0);
      chk("ar_rst_upd_done", 64'(done_ar), 64'd0);
      @(negedge clock);
      @(negedge clock);
      rst_ar = 1'b1;
      r = cyc;
      wait_ar_done(100, u3);
      chk("ar_commit_after_reset", 64'(u3), 64'(r + 67));
      @(negedge clock);
      chk("ar_hex_after_reset", 64'(pk(a5, a4, a3, a2, a1, a0)), 64'(pk(S5, S6, S3, S4, S1, S2)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
